// File: rtl/pkt_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : pkt_traffic_gen
// Purpose  : Multi-port packet source for the hydra switch write side. Each
//            port emits sop, a control word {len, pri, dest}, len counted
//            payload words and eop. Fixed, LFSR-random and incrementing
//            length/destination modes; honours per-port pause; stops each
//            port after pkt_target packets.
// Options  : TG_CHECKSUM_EN - last payload word carries the XOR of the
//            preceding payload words; minimum length becomes 2.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_traffic_gen #(
    parameter int          NUM_PORTS  = 16,
    parameter int          DATA_W     = 16,
    parameter int          DEST_W     = 4,
    parameter int          PRI_W      = 3,
    parameter int          LEN_W      = 9,
    parameter int          MIN_LEN    = 32,
    parameter int          MAX_LEN    = 127,
    parameter int          GAP_CYCLES = 2,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [1:0]                  mode,
    input  logic [LEN_W-1:0]            fixed_len,
    input  logic [PRI_W-1:0]            fixed_pri,
    input  logic [DEST_W-1:0]           fixed_dest,
    input  logic [NUM_PORTS-1:0]        port_en,
    input  logic [15:0]                 pkt_target,
    input  logic [NUM_PORTS-1:0]        pause,
    output logic [NUM_PORTS-1:0]        wr_sop,
    output logic [NUM_PORTS-1:0]        wr_eop,
    output logic [NUM_PORTS-1:0]        wr_vld,
    output logic [NUM_PORTS*DATA_W-1:0] wr_data,
    output logic [NUM_PORTS*16-1:0]     pkt_cnt,
    output logic [NUM_PORTS-1:0]        done,
    output logic                        all_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SOP  = 3'd1,
        S_CTRL = 3'd2,
        S_DATA = 3'd3,
        S_EOP  = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    localparam int               c_FIELD_W = LEN_W + PRI_W + DEST_W;
    localparam logic [LEN_W-1:0] c_MIN_LEN = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_LEN);
`ifdef TG_CHECKSUM_EN
    localparam logic [LEN_W-1:0] c_FLOOR_LEN = LEN_W'(2);
`else
    localparam logic [LEN_W-1:0] c_FLOOR_LEN = LEN_W'(1);
`endif
    localparam int               c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [NUM_PORTS-1:0] w_done;

    // all_done is the AND over enabled ports; an empty enable set is never done
    assign all_done = (|port_en) & (&(w_done | ~port_en));
    assign done     = w_done;

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
            localparam logic [15:0] c_SEED_RAW = SEED ^ 16'(i);
            localparam logic [15:0] c_SEED     = (c_SEED_RAW == 16'd0) ? 16'd1 : c_SEED_RAW;

            state_t              r_state;
            state_t              w_state_nxt;
            logic [LEN_W-1:0]    r_len;
            logic [LEN_W-1:0]    r_k;
            logic [LEN_W-1:0]    r_inc_len;
            logic [PRI_W-1:0]    r_pri;
            logic [DEST_W-1:0]   r_dest;
            logic [DEST_W-1:0]   r_inc_dest;
            logic                r_inc_loaded;
            logic [15:0]         r_lfsr;
            logic [15:0]         r_cnt;
            logic                r_done;
            logic [c_GAP_W-1:0]  r_gap;
`ifdef TG_CHECKSUM_EN
            logic [DATA_W-1:0]   r_csum;
`endif

            logic [LEN_W-1:0]    w_base_len;
            logic [DEST_W-1:0]   w_base_dest;
            logic [LEN_W-1:0]    w_sel_len;
            logic [PRI_W-1:0]    w_sel_pri;
            logic [DEST_W-1:0]   w_sel_dest;
            logic [LEN_W-1:0]    w_inc_len_nxt;
            logic [DEST_W-1:0]   w_inc_dest_nxt;
            logic [LEN_W-1:0]    w_last_k;
            logic [DATA_W-1:0]   w_ctrl;
            logic [DATA_W-1:0]   w_word;
            logic [DATA_W-1:0]   w_data;
            logic [15:0]         w_cnt_inc;
            logic                w_done_set;
            logic                w_limit_now;
            logic                w_limit_eop;
            logic                w_go_base;
            logic                w_sop;
            logic                w_eop;
            logic                w_vld;
            logic                w_lfsr_fb;

            assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
            assign w_cnt_inc   = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
            assign w_done_set  = (pkt_target != 16'd0) && (w_cnt_inc == pkt_target);
            assign w_limit_now = (pkt_target != 16'd0) && (r_cnt >= pkt_target);
            assign w_limit_eop = (pkt_target != 16'd0) && (w_cnt_inc >= pkt_target);
            assign w_go_base   = enable & port_en[i] & ~pause[i] & ~r_done;
            assign w_last_k    = r_len - LEN_W'(1);

            // Header field selection for the packet launched in SOP
            always_comb begin
                w_base_len  = r_inc_loaded ? r_inc_len  : fixed_len;
                w_base_dest = r_inc_loaded ? r_inc_dest : fixed_dest;
                w_sel_len   = fixed_len;
                w_sel_pri   = fixed_pri;
                w_sel_dest  = fixed_dest;
                case (mode)
                    2'd1: begin
                        w_sel_len = r_lfsr[LEN_W-1:0];
                        if (w_sel_len < c_MIN_LEN) begin
                            w_sel_len = c_MIN_LEN;
                        end else if (w_sel_len > c_MAX_LEN) begin
                            w_sel_len = c_MAX_LEN;
                        end
                        w_sel_pri  = r_lfsr[15 -: PRI_W];
                        w_sel_dest = r_lfsr[DEST_W+3:4];
                    end
                    2'd2: begin
                        w_sel_len  = w_base_len;
                        w_sel_dest = w_base_dest;
                    end
                    default: begin
                    end
                endcase
                if (w_sel_len < c_FLOOR_LEN) begin
                    w_sel_len = c_FLOOR_LEN;
                end
                w_inc_len_nxt  = (w_base_len >= c_MAX_LEN) ? c_MIN_LEN : w_base_len + LEN_W'(1);
                w_inc_dest_nxt = w_base_dest + DEST_W'(1);
            end

            // Word on the bus: control word in CTRL, counted payload in DATA
            always_comb begin
                w_ctrl                 = '0;
                w_ctrl[c_FIELD_W-1:0]  = {r_len, r_pri, r_dest};
                w_word                 = '0;
                w_word[LEN_W-1:0]      = r_k;
`ifdef TG_CHECKSUM_EN
                if (r_k == w_last_k) begin
                    w_word = r_csum;
                end
`endif
                w_data = '0;
                case (r_state)
                    S_CTRL:  w_data = w_ctrl;
                    S_DATA:  w_data = w_word;
                    default: w_data = '0;
                endcase
            end

            // State register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= S_IDLE;
                end else begin
                    r_state <= w_state_nxt;
                end
            end

            // Next state and framing strobes; GAP/EOP may launch directly into SOP
            always_comb begin
                w_state_nxt = r_state;
                w_sop       = 1'b0;
                w_eop       = 1'b0;
                w_vld       = 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (w_go_base && !w_limit_now) begin
                            w_state_nxt = S_SOP;
                        end
                    end
                    S_SOP: begin
                        w_sop       = 1'b1;
                        w_state_nxt = S_CTRL;
                    end
                    S_CTRL: begin
                        w_vld = ~pause[i];
                        if (!pause[i]) begin
                            w_state_nxt = S_DATA;
                        end
                    end
                    S_DATA: begin
                        w_vld = ~pause[i];
                        if (!pause[i] && (r_k == w_last_k)) begin
                            w_state_nxt = S_EOP;
                        end
                    end
                    S_EOP: begin
                        w_eop = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            w_state_nxt = S_GAP;
                        end else if (w_go_base && !w_done_set && !w_limit_eop) begin
                            w_state_nxt = S_SOP;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                    S_GAP: begin
                        if (r_gap == c_GAP_LAST) begin
                            w_state_nxt = (w_go_base && !w_limit_now) ? S_SOP : S_IDLE;
                        end
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end

            // Per-port datapath: LFSR, header latch, word counter, packet counter
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_lfsr       <= c_SEED;
                    r_len        <= '0;
                    r_pri        <= '0;
                    r_dest       <= '0;
                    r_k          <= '0;
                    r_inc_len    <= '0;
                    r_inc_dest   <= '0;
                    r_inc_loaded <= 1'b0;
                    r_cnt        <= '0;
                    r_done       <= 1'b0;
                    r_gap        <= '0;
`ifdef TG_CHECKSUM_EN
                    r_csum       <= '0;
`endif
                end else begin
                    r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
                    case (r_state)
                        S_SOP: begin
                            r_len  <= w_sel_len;
                            r_pri  <= w_sel_pri;
                            r_dest <= w_sel_dest;
                            r_k    <= '0;
`ifdef TG_CHECKSUM_EN
                            r_csum <= '0;
`endif
                            if (mode == 2'd2) begin
                                r_inc_len    <= w_inc_len_nxt;
                                r_inc_dest   <= w_inc_dest_nxt;
                                r_inc_loaded <= 1'b1;
                            end
                        end
                        S_DATA: begin
                            if (!pause[i]) begin
                                r_k <= r_k + LEN_W'(1);
`ifdef TG_CHECKSUM_EN
                                r_csum <= r_csum ^ w_word;
`endif
                            end
                        end
                        S_EOP: begin
                            r_cnt <= w_cnt_inc;
                            r_gap <= '0;
                            if (w_done_set) begin
                                r_done <= 1'b1;
                            end
                        end
                        S_GAP: begin
                            r_gap <= r_gap + c_GAP_W'(1);
                        end
                        default: begin
                        end
                    endcase
                end
            end

            assign wr_sop[i]                   = w_sop;
            assign wr_eop[i]                   = w_eop;
            assign wr_vld[i]                   = w_vld;
            assign wr_data[i*DATA_W +: DATA_W] = w_data;
            assign pkt_cnt[i*16 +: 16]         = r_cnt;
            assign w_done[i]                   = r_done;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pkt_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_traffic_gen
// Purpose  : Directed self-checking bench for pkt_traffic_gen (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_traffic_gen;
    localparam int NP  = 16;
    localparam int DW  = 16;
    localparam int LW  = 9;
    localparam int PW  = 3;
    localparam int DEW = 4;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic [1:0]         mode;
    logic [LW-1:0]      fixed_len;
    logic [PW-1:0]      fixed_pri;
    logic [DEW-1:0]     fixed_dest;
    logic [NP-1:0]      port_en;
    logic [15:0]        pkt_target;
    logic [NP-1:0]      pause;
    logic [NP-1:0]      wr_sop;
    logic [NP-1:0]      wr_eop;
    logic [NP-1:0]      wr_vld;
    logic [NP*DW-1:0]   wr_data;
    logic [NP*16-1:0]   pkt_cnt;
    logic [NP-1:0]      done;
    logic               all_done;

    int checks;
    int failures;
    int n;
    int bad;
    int eops;
    int range_bad;
    int payload_bad;
    int len_bad;
    int cnt_bad;
    logic seen;
    int plen [NP];
    int kcnt [NP];
    logic in_ctrl [NP];
    logic [DW-1:0] w;
    logic [15:0] exp_m2 [3];

    pkt_traffic_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode       (mode),
        .fixed_len  (fixed_len),
        .fixed_pri  (fixed_pri),
        .fixed_dest (fixed_dest),
        .port_en    (port_en),
        .pkt_target (pkt_target),
        .pause      (pause),
        .wr_sop     (wr_sop),
        .wr_eop     (wr_eop),
        .wr_vld     (wr_vld),
        .wr_data    (wr_data),
        .pkt_cnt    (pkt_cnt),
        .done       (done),
        .all_done   (all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic init_and_reset(input logic [15:0] tgt);
        rst_n      = 1'b0;
        enable     = 1'b0;
        mode       = 2'd0;
        fixed_len  = 9'd32;
        fixed_pri  = 3'd2;
        fixed_dest = 4'd5;
        port_en    = 16'h0001;
        pkt_target = tgt;
        pause      = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_sop(input int budget);
        int t;
        t = 0;
        while (!wr_sop[0] && t < budget) begin
            step();
            t++;
        end
        check("sop_arrival", wr_sop[0], 1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_m2[0] = 16'h3F1F;
        exp_m2[1] = 16'h3F90;
        exp_m2[2] = 16'h1011;

        // Reset state
        init_and_reset(16'd1);
        rst_n = 1'b0;
        #1;
        check("rst_sop",      wr_sop, 0);
        check("rst_vld",      wr_vld, 0);
        check("rst_data_nz",  (wr_data != '0), 0);
        check("rst_cnt_nz",   (pkt_cnt != '0), 0);
        check("rst_done",     done, 0);
        check("rst_all_done", all_done, 0);
        rst_n = 1'b1;
        step();
        port_en = '0;
        #1;
        check("all_done_no_ports", all_done, 0);

        // Mode 0, single packet
        init_and_reset(16'd1);
        enable = 1'b1;
        wait_sop(10);
        check("t1_sop_vld", wr_vld[0], 0);
        step();
        check("t1_ctrl_vld", wr_vld[0], 1);
        check("t1_ctrl", wr_data[DW-1:0], 16'h1025);
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            if (!(wr_vld[0] && wr_data[DW-1:0] == 16'(k))) bad++;
        end
        check("t1_payload_bad", bad, 0);
        step();
        check("t1_eop", wr_eop[0], 1);
        check("t1_eop_vld", wr_vld[0], 0);
        step();
        check("t1_cnt", pkt_cnt[15:0], 1);
        check("t1_done", done[0], 1);
        check("t1_all_done", all_done, 1);
        seen = 1'b0;
        repeat (10) begin
            step();
            seen |= wr_sop[0];
        end
        check("t1_no_more_sop", seen, 0);

        // Two packets: sop spacing len+3+GAP
        init_and_reset(16'd2);
        enable = 1'b1;
        wait_sop(10);
        n = 0;
        do begin
            step();
            n++;
        end while (!wr_sop[0] && n < 60);
        check("t2_sop_spacing", n, 37);
        n = 0;
        while (!wr_eop[0] && n < 60) begin
            step();
            n++;
        end
        check("t2_eop", wr_eop[0], 1);
        step();
        check("t2_cnt", pkt_cnt[15:0], 2);
        check("t2_done", done[0], 1);

        // Pause for 5 cycles at data word 10
        init_and_reset(16'd1);
        enable = 1'b1;
        wait_sop(10);
        step();
        repeat (10) step();
        check("t3_word9", wr_data[DW-1:0], 9);
        pause[0] = 1'b1;
        bad = 0;
        repeat (5) begin
            step();
            if (wr_vld[0]) bad++;
        end
        check("t3_paused_vld", bad, 0);
        pause[0] = 1'b0;
        step();
        check("t3_resume_vld", wr_vld[0], 1);
        check("t3_resume_word", wr_data[DW-1:0], 10);
        repeat (22) step();
        check("t3_eop_at_39", wr_eop[0], 1);

        // Mode 2 incrementing length/destination with wrap
        init_and_reset(16'd3);
        mode       = 2'd2;
        fixed_len  = 9'd126;
        fixed_dest = 4'd15;
        fixed_pri  = 3'd1;
        enable     = 1'b1;
        for (int p = 0; p < 3; p++) begin
            wait_sop(300);
            step();
            check("t4_ctrl", wr_data[DW-1:0], 64'(exp_m2[p]));
        end

        // Mode 1 random on all ports
        init_and_reset(16'd50);
        mode    = 2'd1;
        port_en = '1;
        for (int p = 0; p < NP; p++) begin
            plen[p]    = 0;
            kcnt[p]    = 0;
            in_ctrl[p] = 1'b0;
        end
        eops = 0; range_bad = 0; payload_bad = 0; len_bad = 0; cnt_bad = 0;
        enable = 1'b1;
        n = 0;
        while (!all_done && n < 20000) begin
            step();
            n++;
            for (int p = 0; p < NP; p++) begin
                w = wr_data[p*DW +: DW];
                if (wr_sop[p]) begin
                    in_ctrl[p] = 1'b1;
                    kcnt[p]    = 0;
                end else if (wr_vld[p]) begin
                    if (in_ctrl[p]) begin
                        in_ctrl[p] = 1'b0;
                        plen[p]    = int'(w[15:7]);
                        if (plen[p] < 32 || plen[p] > 127) range_bad++;
                    end else begin
                        if (w != DW'(kcnt[p])) payload_bad++;
                        kcnt[p]++;
                    end
                end
                if (wr_eop[p]) begin
                    eops++;
                    if (kcnt[p] != plen[p]) len_bad++;
                end
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (pkt_cnt[p*16 +: 16] != 16'd50) cnt_bad++;
        end
        check("t5_all_done", all_done, 1);
        check("t5_eops", eops, 800);
        check("t5_len_range_bad", range_bad, 0);
        check("t5_payload_bad", payload_bad, 0);
        check("t5_len_count_bad", len_bad, 0);
        check("t5_pkt_cnt_bad", cnt_bad, 0);

        // Asynchronous reset in the middle of the second packet
        init_and_reset(16'd0);
        enable = 1'b1;
        wait_sop(10);
        n = 0;
        do begin
            step();
            n++;
        end while (!wr_sop[0] && n < 60);
        check("t6_second_sop", wr_sop[0], 1);
        step();
        repeat (4) step();
        check("t6_pre_cnt", pkt_cnt[15:0], 1);
        check("t6_pre_word", wr_data[DW-1:0], 3);
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld", wr_vld, 0);
        check("t6_rst_eop", wr_eop, 0);
        check("t6_rst_data_nz", (wr_data != '0), 0);
        check("t6_rst_cnt", pkt_cnt[15:0], 0);
        fixed_len = 9'd8;
        step();
        step();
        rst_n = 1'b1;
        wait_sop(5);
        check("t6_post_cnt", pkt_cnt[15:0], 0);
        step();
        check("t6_post_ctrl", wr_data[DW-1:0], 16'h0425);

        // Enable dropped mid-packet: packet completes, no new launch
        init_and_reset(16'd0);
        fixed_len = 9'd4;
        enable    = 1'b1;
        wait_sop(10);
        step();
        step();
        enable = 1'b0;
        n = 0;
        while (!wr_eop[0] && n < 10) begin
            step();
            n++;
        end
        check("t7_eop", wr_eop[0], 1);
        seen = 1'b0;
        repeat (12) begin
            step();
            seen |= wr_sop[0];
        end
        check("t7_no_sop", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
